// File: rtl/sc_game_pkg.sv
// Shared game definitions: FSM state encoding, phase codes for the select stage,
// and the Moore output decode used by the phase counter.
package sc_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_PLAY       = 3'd2,
    ST_CRASH_HOLD = 3'd3,
    ST_GAMEOVER   = 3'd4
  } game_state_e;

  localparam int          PHASE_W       = 2;
  localparam logic [1:0]  PHASE_BLANK   = 2'd1;
  localparam logic [1:0]  PHASE_TRAFFIC = 2'd2;

  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic               playen;
    logic               gameover;
  } game_out_t;

  // Undefined encodings decode like IDLE so the outputs stay benign for the
  // single cycle before the FSM recovers.
  function automatic game_out_t decode_state(input game_state_e state);
    game_out_t out;
    out = '{phase: PHASE_BLANK, playen: 1'b0, gameover: 1'b0};
    case (state)
      ST_PLAY:       begin out.phase = PHASE_TRAFFIC; out.playen = 1'b1; end
      ST_CRASH_HOLD: out.phase = PHASE_TRAFFIC;
      ST_GAMEOVER:   out.gameover = 1'b1;
      default:       out.phase = PHASE_BLANK;
    endcase
    return out;
  endfunction

endpackage

// File: rtl/sc_startsync.sv
// Start button conditioning: two-flop synchroniser for the asynchronous active-low
// pin followed by a falling-edge detector giving a one-cycle start pulse.
module sc_startsync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_n_i,
  output logic start_pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // All three flops reset to 1 (button released) so reset never fakes a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous stage's
      // old value, so this is a real shift chain rather than one collapsed flop.
      sync1_q <= start_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // High for exactly one cycle after the synchronised level goes 1 -> 0; a held
  // button keeps both flops at 0 and cannot pulse again.
  assign start_pulse_o = prev_q & ~sync2_q;

endmodule

// File: rtl/sc_phasecounter.sv
// Game-phase sequencer: IDLE -> countdown -> play -> crash hold -> game over,
// producing the phase code for the row-select stage plus display status.
module sc_phasecounter
  import sc_game_pkg::*;
#(
  parameter int PHASE_WIDTH = 2,
  parameter int COUNT_WIDTH = 2,
  parameter int COUNT_TICKS = 3,
  parameter int HOLD_TICKS  = 2,
  parameter int LIVES_WIDTH = 2,
  parameter int LIVES_INIT  = 3
) (
  input  logic                   SC_PHASECOUNTER_CLOCK_50,
  input  logic                   SC_PHASECOUNTER_RESET_InHigh,
  input  logic                   SC_PHASECOUNTER_START_InLow,
  input  logic                   SC_PHASECOUNTER_TICK_InHigh,
  input  logic                   SC_PHASECOUNTER_CRASH_InHigh,
  output logic [PHASE_WIDTH-1:0] SC_PHASECOUNTER_PHASE_Out,
  output logic [COUNT_WIDTH-1:0] SC_PHASECOUNTER_COUNT_Out,
  output logic [LIVES_WIDTH-1:0] SC_PHASECOUNTER_LIVES_Out,
  output logic                   SC_PHASECOUNTER_PLAYEN_OutHigh,
  output logic                   SC_PHASECOUNTER_GAMEOVER_OutHigh
);

  localparam int HOLD_WIDTH = $clog2(HOLD_TICKS + 1);

  localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(COUNT_TICKS);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_LOAD  = HOLD_WIDTH'(HOLD_TICKS);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_ONE   = HOLD_WIDTH'(1);
  localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ONE  = LIVES_WIDTH'(1);

  logic clk;
  logic rst;
  logic tick;
  logic crash;
  logic start_pulse;

  assign clk   = SC_PHASECOUNTER_CLOCK_50;
  assign rst   = SC_PHASECOUNTER_RESET_InHigh;
  assign tick  = SC_PHASECOUNTER_TICK_InHigh;
  assign crash = SC_PHASECOUNTER_CRASH_InHigh;

  sc_startsync u_startsync (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_n_i     (SC_PHASECOUNTER_START_InLow),
    .start_pulse_o (start_pulse)
  );

  game_state_e            state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [HOLD_WIDTH-1:0]  hold_q,  hold_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  game_out_t              out_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so branches that
    // leave one unassigned cannot infer a latch.
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    lives_d = lives_q;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d = ST_COUNTDOWN;
          count_d = COUNT_LOAD;
        end
      end

      ST_COUNTDOWN: begin
        if (tick) begin
          if (count_q == COUNT_ONE) begin
            state_d = ST_PLAY;
            count_d = '0;
          end else begin
            count_d = count_q - COUNT_ONE;
          end
        end
      end

      // Only a crash matters here; a same-cycle tick is simply not looked at.
      ST_PLAY: begin
        if (crash) begin
          state_d = ST_CRASH_HOLD;
          hold_d  = HOLD_LOAD;
          if (lives_q != '0) lives_d = lives_q - LIVES_ONE;
        end
      end

      ST_CRASH_HOLD: begin
        if (tick) begin
          hold_d = hold_q - HOLD_ONE;
          if (hold_q == HOLD_ONE) state_d = (lives_q != '0) ? ST_PLAY : ST_GAMEOVER;
        end
      end

      ST_GAMEOVER: begin
        if (start_pulse) begin
          state_d = ST_COUNTDOWN;
          count_d = COUNT_LOAD;
          lives_d = LIVES_LOAD;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the decoded next state, so they line up with
  // state_q exactly and carry no combinational path to the select stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      hold_q  <= '0;
      lives_q <= LIVES_LOAD;
      out_q   <= decode_state(ST_IDLE);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      lives_q <= lives_d;
      out_q   <= decode_state(state_d);
    end
  end

  assign SC_PHASECOUNTER_PHASE_Out        = PHASE_WIDTH'(out_q.phase);
  assign SC_PHASECOUNTER_COUNT_Out        = count_q;
  assign SC_PHASECOUNTER_LIVES_Out        = lives_q;
  assign SC_PHASECOUNTER_PLAYEN_OutHigh   = out_q.playen;
  assign SC_PHASECOUNTER_GAMEOVER_OutHigh = out_q.gameover;

endmodule
